// File: rtl/sparc_cu_pkg.sv
// sparc_cu_pkg: shared definitions for the SPARC control-unit microsequencer.
// Holds the 5-bit state codes (shared with the instruction encoder's
// nextState), the list of states the encoder may legally dispatch to, and
// helper functions for dispatch legality, MOC-wait detection and the Moore
// output decode of a state code.
package sparc_cu_pkg;

  localparam int SW = 5;

  localparam logic [4:0] S_RESET        = 5'd0;
  localparam logic [4:0] S_FETCH_ADDR   = 5'd1;
  localparam logic [4:0] S_FETCH_WAIT   = 5'd2;
  localparam logic [4:0] S_IR_LOAD      = 5'd3;
  localparam logic [4:0] S_DECODE       = 5'd4;
  localparam logic [4:0] S_ALU_RR       = 5'd5;
  localparam logic [4:0] S_ALU_RRCC     = 5'd6;
  localparam logic [4:0] S_ALU_IMM      = 5'd7;
  localparam logic [4:0] S_ALU_IMMCC    = 5'd8;
  localparam logic [4:0] S_SETHI        = 5'd9;
  localparam logic [4:0] S_CALL         = 5'd10;
  localparam logic [4:0] S_CALL_LINK    = 5'd11;
  localparam logic [4:0] S_JMPL         = 5'd12;
  localparam logic [4:0] S_JMPL_LINK    = 5'd13;
  localparam logic [4:0] S_LOAD_ADDR    = 5'd16;
  localparam logic [4:0] S_LOAD_WAIT    = 5'd17;
  localparam logic [4:0] S_LOAD_WB      = 5'd18;
  localparam logic [4:0] S_LOAD_ADDR_I  = 5'd20;
  localparam logic [4:0] S_STORE_ADDR   = 5'd21;
  localparam logic [4:0] S_STORE_WAIT   = 5'd22;
  localparam logic [4:0] S_STORE_DONE   = 5'd23;
  localparam logic [4:0] S_STORE_ADDR_I = 5'd24;
  localparam logic [4:0] S_BR_EVAL      = 5'd25;
  localparam logic [4:0] S_BR_TAKE      = 5'd26;
  localparam logic [4:0] S_ANNUL_SKIP   = 5'd27;
  localparam logic [4:0] S_TRAP         = 5'd31;

  // States the encoder is allowed to hand over in DECODE.
  localparam int N_LEGAL = 12;
  localparam logic [N_LEGAL-1:0][4:0] LEGAL_DISPATCH = {
    S_ALU_RR, S_ALU_RRCC, S_ALU_IMM, S_ALU_IMMCC, S_SETHI, S_CALL,
    S_JMPL, S_LOAD_ADDR, S_LOAD_ADDR_I, S_STORE_ADDR, S_STORE_ADDR_I,
    S_BR_EVAL
  };

  typedef struct packed {
    logic mem_req;
    logic mem_rw;
    logic ir_ld;
    logic pc_ld;
    logic npc_ld;
    logic rf_we;
  } cu_out_t;

  function automatic logic is_legal_dispatch(input logic [4:0] d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (d == LEGAL_DISPATCH[i]) begin
        ok = 1'b1;
      end
    end
    return ok;
  endfunction

  function automatic logic is_moc_wait(input logic [4:0] s);
    return (s == S_FETCH_WAIT) || (s == S_LOAD_WAIT) || (s == S_STORE_WAIT);
  endfunction

  // Moore output decode; mem_rw idles at read.
  function automatic cu_out_t cu_decode(input logic [4:0] s);
    cu_out_t o;
    o = '{mem_req: 1'b0, mem_rw: 1'b1, ir_ld: 1'b0, pc_ld: 1'b0,
          npc_ld: 1'b0, rf_we: 1'b0};
    case (s)
      S_FETCH_ADDR, S_FETCH_WAIT, S_LOAD_ADDR, S_LOAD_WAIT,
      S_LOAD_ADDR_I: begin
        o.mem_req = 1'b1;
      end
      S_STORE_ADDR, S_STORE_WAIT, S_STORE_ADDR_I: begin
        o.mem_req = 1'b1;
        o.mem_rw  = 1'b0;
      end
      S_IR_LOAD: begin
        o.ir_ld  = 1'b1;
        o.pc_ld  = 1'b1;
        o.npc_ld = 1'b1;
      end
      S_CALL_LINK, S_JMPL_LINK, S_BR_TAKE: begin
        o.npc_ld = 1'b1;
      end
      S_ANNUL_SKIP: begin
        o.pc_ld  = 1'b1;
        o.npc_ld = 1'b1;
      end
      S_ALU_RR, S_ALU_RRCC, S_ALU_IMM, S_ALU_IMMCC, S_SETHI, S_CALL,
      S_JMPL, S_LOAD_WB: begin
        o.rf_we = 1'b1;
      end
      default: begin
        o.mem_rw = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/moc_timer.sv
// moc_timer: cycle counter for memory-operation-complete waits.
// Ports:
//  clk, clr_n  clock / asynchronous active-low reset
//  clear       restart the count at zero (takes priority over enable)
//  enable      count one waited cycle
//  expire      count has reached MOC_TIMEOUT-1 (the last allowed wait cycle)
module moc_timer #(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(MOC_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter: clear on entry, advance on each enabled cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == LAST_C);

endmodule

// File: rtl/cu_microsequencer.sv
// cu_microsequencer: control-unit state register and sequencer.
// Runs fetch, dispatches in DECODE to the encoder's state, steps execute
// sequences, waits on MOC with a timeout, and traps on illegal states or
// memory timeout. Outputs are registered copies of the decode of the state
// being entered, so they always equal the decode of the state register.
// Ports:
//  clk, clr_n       clock / asynchronous active-low reset
//  dispatch_state   encoder next state, sampled in DECODE
//  moc              memory operation complete
//  cond_true, annul branch condition result and annul bit (BR_EVAL)
//  hold             freeze state and timeout counter
//  state            current state register
//  mem_req, mem_rw, ir_ld, pc_ld, npc_ld, rf_we  datapath controls
//  illegal_op, mem_fault                          sticky trap causes
module cu_microsequencer
  import sparc_cu_pkg::*;
#(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [4:0] dispatch_state,
  input  logic       moc,
  input  logic       cond_true,
  input  logic       annul,
  input  logic       hold,
  output logic [4:0] state,
  output logic       mem_req,
  output logic       mem_rw,
  output logic       ir_ld,
  output logic       pc_ld,
  output logic       npc_ld,
  output logic       rf_we,
  output logic       illegal_op,
  output logic       mem_fault
);

  logic [4:0] state_r;
  logic [4:0] next_state_s;
  logic       set_illegal_s;
  logic       set_fault_s;
  logic       expire_s;
  logic       cnt_clear_s;
  logic       cnt_en_s;
  cu_out_t    out_r;
  cu_out_t    next_out_s;
  logic       illegal_op_r;
  logic       mem_fault_r;

  moc_timer #(.MOC_TIMEOUT(MOC_TIMEOUT)) u_moc_timer (
    .clk    (clk),
    .clr_n  (clr_n),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .expire (expire_s)
  );

  // Counter restarts only on a real entry into a wait state.
  assign cnt_clear_s = !hold && is_moc_wait(next_state_s) && (next_state_s != state_r);
  assign cnt_en_s    = !hold && is_moc_wait(state_r) && !moc;
  assign next_out_s  = cu_decode(next_state_s);

  // Next-state selection; moc wins over timeout on the last wait cycle.
  always_comb begin
    next_state_s  = state_r;
    set_illegal_s = 1'b0;
    set_fault_s   = 1'b0;
    if (hold) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        S_RESET:      next_state_s = S_FETCH_ADDR;
        S_FETCH_ADDR: next_state_s = S_FETCH_WAIT;
        S_IR_LOAD:    next_state_s = S_DECODE;
        S_DECODE: begin
          if (is_legal_dispatch(dispatch_state)) begin
            next_state_s = dispatch_state;
          end else begin
            next_state_s  = S_TRAP;
            set_illegal_s = 1'b1;
          end
        end
        S_ALU_RR, S_ALU_RRCC, S_ALU_IMM, S_ALU_IMMCC, S_SETHI,
        S_CALL_LINK, S_JMPL_LINK, S_LOAD_WB, S_STORE_DONE,
        S_BR_TAKE, S_ANNUL_SKIP: next_state_s = S_FETCH_ADDR;
        S_CALL:         next_state_s = S_CALL_LINK;
        S_JMPL:         next_state_s = S_JMPL_LINK;
        S_LOAD_ADDR,
        S_LOAD_ADDR_I:  next_state_s = S_LOAD_WAIT;
        S_STORE_ADDR,
        S_STORE_ADDR_I: next_state_s = S_STORE_WAIT;
        S_FETCH_WAIT, S_LOAD_WAIT, S_STORE_WAIT: begin
          if (moc) begin
            next_state_s = state_r + 5'd1;
          end else if (expire_s) begin
            next_state_s = S_TRAP;
            set_fault_s  = 1'b1;
          end else begin
            next_state_s = state_r;
          end
        end
        S_BR_EVAL: begin
          if (cond_true) begin
            next_state_s = S_BR_TAKE;
          end else if (annul) begin
            next_state_s = S_ANNUL_SKIP;
          end else begin
            next_state_s = S_FETCH_ADDR;
          end
        end
        S_TRAP: next_state_s = S_TRAP;
        default: begin
          next_state_s  = S_TRAP;
          set_illegal_s = 1'b1;
        end
      endcase
    end
  end

  // State, output and sticky-flag registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r      <= S_RESET;
      out_r        <= '{mem_req: 1'b0, mem_rw: 1'b1, ir_ld: 1'b0,
                        pc_ld: 1'b0, npc_ld: 1'b0, rf_we: 1'b0};
      illegal_op_r <= 1'b0;
      mem_fault_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      out_r        <= next_out_s;
      illegal_op_r <= illegal_op_r | set_illegal_s;
      mem_fault_r  <= mem_fault_r | set_fault_s;
    end
  end

  assign state      = state_r;
  assign mem_req    = out_r.mem_req;
  assign mem_rw     = out_r.mem_rw;
  assign ir_ld      = out_r.ir_ld;
  assign pc_ld      = out_r.pc_ld;
  assign npc_ld     = out_r.npc_ld;
  assign rf_we      = out_r.rf_we;
  assign illegal_op = illegal_op_r;
  assign mem_fault  = mem_fault_r;

endmodule
